apu_mixer: RTL and testbench

Parametrised, time-multiplexed audio mixer and sigma-delta output stage for the APU. It generalises the fixed four-channel adder-plus-PWM path. It mixes any number of unsigned channel levels, applying a programmable per-channel gain and mute, then scales and saturates the sum. The mixed sample drives a first-order sigma-delta modulator that produces a 1-bit audio output. The block sits between the tone generators (square, triangle, noise, …) and the board's audio pin.

---
 rtl/apu_mixer.sv | 129 ++++++++++++
 tb/tb_apu_mixer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_mixer.sv
// apu_mixer: time-multiplexed N-channel gain/mute mixer with saturation
// and a first-order sigma-delta 1-bit output stage.
module apu_mixer #(
    parameter int CHANNELS   = 4,
    parameter int IN_WIDTH   = 4,
    parameter int GAIN_WIDTH = 4,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 2,
    parameter int ADDR_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*IN_WIDTH-1:0] ch_data,
    input  logic [CHANNELS-1:0]          mute,
    input  logic                         gain_we,
    input  logic [ADDR_WIDTH-1:0]        gain_addr,
    input  logic [GAIN_WIDTH-1:0]        gain_data,
    output logic [OUT_WIDTH-1:0]         sample,
    output logic                         sample_valid,
    output logic                         clip,
    output logic                         pwm
);

    localparam int CH_LOG = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
    localparam int ACC_W  = IN_WIDTH + GAIN_WIDTH + CH_LOG;
    // m is widened so the saturation test always has an upper slice
    localparam int M_W    = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(CHANNELS - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state;

    logic [CHANNELS-1:0][GAIN_WIDTH-1:0] gains;
    logic [CHANNELS-1:0][GAIN_WIDTH-1:0] gain_s;
    logic [CHANNELS-1:0][IN_WIDTH-1:0]   ch_s;
    logic [CHANNELS-1:0]                 mute_s;

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      term;
    logic [ADDR_WIDTH-1:0] idx;
    logic [M_W-1:0]        m;
    logic                  sat;
    logic [OUT_WIDTH:0]    sd;

    // Gain register file; out-of-range addresses match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gains <= '1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (gain_we && gain_addr == ADDR_WIDTH'(i)) begin
                    gains[i] <= gain_data;
                end
            end
        end
    end

    always_comb begin
        term = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == ADDR_WIDTH'(i) && !mute_s[i]) begin
                term = ACC_W'(ch_s[i]) * ACC_W'(gain_s[i]);
            end
        end
    end

    assign m   = M_W'(acc) >> SHIFT;
    assign sat = |m[M_W-1:OUT_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            acc          <= '0;
            idx          <= '0;
            ch_s         <= '0;
            mute_s       <= '0;
            gain_s       <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (state)
                LOAD: begin
                    ch_s   <= ch_data;
                    mute_s <= mute;
                    gain_s <= gains;
                    acc    <= '0;
                    idx    <= '0;
                    state  <= ACC;
                end
                ACC: begin
                    acc <= acc + term;
                    idx <= idx + ADDR_WIDTH'(1);
                    if (idx == LAST_IDX) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    sample       <= sat ? '1 : m[OUT_WIDTH-1:0];
                    clip         <= sat;
                    sample_valid <= 1'b1;
                    state        <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // Carry out of the phase accumulator is the 1-bit density stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd  <= '0;
            pwm <= 1'b0;
        end else begin
            sd  <= {1'b0, sd[OUT_WIDTH-1:0]} + {1'b0, sample};
            pwm <= sd[OUT_WIDTH];
        end
    end

endmodule

// File: tb/tb_apu_mixer.sv
// tb_apu_mixer: directed plus random checks of two mixer configurations
// against a frame-level arithmetic reference model.
module tb_apu_mixer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] ch_data;
    logic [3:0]  mute;
    logic        gain_we;
    logic [1:0]  gain_addr;
    logic [3:0]  gain_data;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        clip;
    logic        pwm;

    logic [11:0] ch_data2;
    logic [2:0]  mute2;
    logic        gain_we2;
    logic [2:0]  gain_addr2;
    logic [3:0]  gain_data2;
    logic [7:0]  sample2;
    logic        sample_valid2;
    logic        clip2;
    logic        pwm2;

    int total = 0;
    int bad   = 0;

    int per[2] = '{6, 5};
    int nch[2] = '{4, 3};
    int shf[2] = '{2, 1};

    int         ecnt[2];
    int         lastpos[2];
    int         mg[2][4];
    logic [8:0] pend[2];
    logic [8:0] last[2];
    int         ones[2];

    apu_mixer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_data      (ch_data),
        .mute         (mute),
        .gain_we      (gain_we),
        .gain_addr    (gain_addr),
        .gain_data    (gain_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .clip         (clip),
        .pwm          (pwm)
    );

    apu_mixer #(
        .CHANNELS   (3),
        .SHIFT      (1),
        .ADDR_WIDTH (3)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_data      (ch_data2),
        .mute         (mute2),
        .gain_we      (gain_we2),
        .gain_addr    (gain_addr2),
        .gain_data    (gain_data2),
        .sample       (sample2),
        .sample_valid (sample_valid2),
        .clip         (clip2),
        .pwm          (pwm2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // {clip, sample} of one frame from levels, mutes and gains
    function automatic logic [8:0] mix(input int lv[4], input logic [3:0] mu,
                                       input int g[4], input int n,
                                       input int sh);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            if (!mu[i]) s += lv[i] * g[i];
        end
        s = s >> sh;
        if (s > 255) return 9'h1ff;
        return {1'b0, 8'(s)};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ecnt[d]    = 0;
            lastpos[d] = -1;
            pend[d]    = '0;
            last[d]    = '0;
            for (int i = 0; i < 4; i++) mg[d][i] = 15;
        end
    endtask

    // One clock edge: snapshot at frame start, then apply writes, then check.
    task automatic tick();
        int         pos[2];
        int         lv[4];
        int         g[4];
        logic [3:0] mu;
        logic       we;
        int         a;
        int         dat;
        logic       v;
        logic [8:0] o;
        for (int d = 0; d < 2; d++) begin
            ecnt[d]++;
            pos[d] = (ecnt[d] - 1) % per[d];
            for (int i = 0; i < 4; i++) begin
                lv[i] = 0;
                g[i]  = mg[d][i];
            end
            if (d == 0) begin
                for (int i = 0; i < 4; i++) lv[i] = int'(ch_data[i*4 +: 4]);
                mu  = mute;
                we  = gain_we;
                a   = int'(gain_addr);
                dat = int'(gain_data);
            end else begin
                for (int i = 0; i < 3; i++) lv[i] = int'(ch_data2[i*4 +: 4]);
                mu  = {1'b0, mute2};
                we  = gain_we2;
                a   = int'(gain_addr2);
                dat = int'(gain_data2);
            end
            if (pos[d] == 0) pend[d] = mix(lv, mu, g, nch[d], shf[d]);
            if (we && a < nch[d]) mg[d][a] = dat;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            v = (d == 0) ? sample_valid : sample_valid2;
            o = (d == 0) ? {clip, sample} : {clip2, sample2};
            if (pos[d] == per[d] - 1) begin
                chk($sformatf("d%0d_valid_hi", d), 32'(v), 32'd1);
                chk($sformatf("d%0d_sample", d), 32'(o), 32'(pend[d]));
                last[d] = pend[d];
            end else begin
                chk($sformatf("d%0d_valid_lo", d), 32'(v), 32'd0);
                chk($sformatf("d%0d_hold", d), 32'(o), 32'(last[d]));
            end
            lastpos[d] = pos[d];
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_pos(input int d, input int p);
        for (int k = 0; k < 20; k++) begin
            if (lastpos[d] == p) return;
            tick();
        end
        chk("wait_pos_timeout", 32'(lastpos[d]), 32'(p));
    endtask

    task automatic pwm_count();
        ones[0] = 0;
        ones[1] = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            ones[0] += int'(pwm);
            ones[1] += int'(pwm2);
        end
        chk("d0_pwm_ones", 32'(ones[0]), 32'(last[0][7:0]));
        chk("d1_pwm_ones", 32'(ones[1]), 32'(last[1][7:0]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_d0"}, 32'({sample, sample_valid, clip, pwm}), 32'd0);
        chk({tag, "_d1"}, 32'({sample2, sample_valid2, clip2, pwm2}), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ch_data    = 16'hffff;
        mute       = 4'h0;
        gain_we    = 1'b0;
        gain_addr  = 2'd0;
        gain_data  = 4'd0;
        ch_data2   = 12'hfff;
        mute2      = 3'h0;
        gain_we2   = 1'b0;
        gain_addr2 = 3'd0;
        gain_data2 = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // all levels max, reset gains
        ticks(18);

        // mute channel 1, then unmute during accumulation
        mute = 4'b0010;
        ticks(12);
        wait_pos(0, 1);
        mute = 4'b0000;
        ticks(12);

        // gain write mid-frame; out-of-range write on the 3-channel unit
        wait_pos(0, 2);
        gain_we    = 1'b1;
        gain_addr  = 2'd2;
        gain_data  = 4'd0;
        gain_we2   = 1'b1;
        gain_addr2 = 3'd4;
        gain_data2 = 4'd0;
        tick();
        gain_we  = 1'b0;
        gain_we2 = 1'b0;
        ticks(12);

        // gain write coinciding with the snapshot cycle
        wait_pos(0, 5);
        gain_we   = 1'b1;
        gain_addr = 2'd2;
        gain_data = 4'd15;
        tick();
        gain_we = 1'b0;
        ticks(12);

        // density: 64 on the 4-channel unit, clipped 255 on the other
        for (int i = 0; i < 4; i++) begin
            gain_we   = 1'b1;
            gain_addr = 2'(i);
            gain_data = 4'd8;
            tick();
        end
        gain_we = 1'b0;
        ch_data = 16'h8888;
        ticks(18);
        pwm_count();

        // density: silent output, and a tiny level on the other unit
        mute = 4'hf;
        for (int i = 0; i < 3; i++) begin
            gain_we2   = 1'b1;
            gain_addr2 = 3'(i);
            gain_data2 = 4'd1;
            tick();
        end
        gain_we2 = 1'b0;
        ch_data2 = 12'h111;
        ticks(18);
        pwm_count();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) ch_data = 16'($urandom);
            if ($urandom_range(0, 5) == 0) ch_data2 = 12'($urandom);
            if ($urandom_range(0, 7) == 0) mute = 4'($urandom);
            if ($urandom_range(0, 7) == 0) mute2 = 3'($urandom);
            gain_we    = ($urandom_range(0, 3) == 0);
            gain_addr  = 2'($urandom);
            gain_data  = 4'($urandom);
            gain_we2   = ($urandom_range(0, 3) == 0);
            gain_addr2 = 3'($urandom_range(0, 7));
            gain_data2 = 4'($urandom);
            tick();
        end
        gain_we  = 1'b0;
        gain_we2 = 1'b0;
        ticks(12);

        // reset mid-accumulation after a gain write
        gain_we   = 1'b1;
        gain_addr = 2'd0;
        gain_data = 4'd3;
        tick();
        gain_we = 1'b0;
        wait_pos(0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        ch_data  = 16'hffff;
        mute     = 4'h0;
        ch_data2 = 12'hfff;
        mute2    = 3'h0;
        rst_n    = 1'b1;
        ticks(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
